// File: rtl/rgb_led_pkg.sv
// Shared types and helpers for the RGB LED PWM controller.
// Holds the per-LED mode encoding, the configuration record stored by each
// channel and the effective-duty calculation used by every colour.
package rgb_led_pkg;

   localparam int MODE_W     = 2;
   // Widest duty field a channel can store; PWM_BITS must not exceed it.
   localparam int CFG_DUTY_W = 16;

   typedef enum logic [MODE_W-1:0] {
      MODE_OFF     = 2'd0,
      MODE_STEADY  = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } led_mode_e;

   // Breathe ramp direction; each end value is held for one extra step
   // while the direction flips.
   typedef enum logic {
      RAMP_UP   = 1'b0,
      RAMP_DOWN = 1'b1
   } ramp_dir_e;

   typedef struct packed {
      led_mode_e               mode;
      logic [CFG_DUTY_W-1:0]   r;
      logic [CFG_DUTY_W-1:0]   g;
      logic [CFG_DUTY_W-1:0]   b;
   } led_cfg_t;

   localparam led_cfg_t CFG_RESET = '{mode: MODE_OFF, r: '0, g: '0, b: '0};

   // Effective duty of one colour. Duty and ramp arrive zero-extended to
   // CFG_DUTY_W, so the full-width product equals the PWM_BITS-wide product
   // and the shift by pwm_bits truncates exactly as a narrow multiply would.
   function automatic logic [CFG_DUTY_W-1:0] eff_duty(
      input led_mode_e             mode,
      input logic [CFG_DUTY_W-1:0] duty,
      input logic                  blink_on,
      input logic [CFG_DUTY_W-1:0] ramp,
      input int                    pwm_bits
   );
      logic [2*CFG_DUTY_W-1:0] prod;
      prod = {{CFG_DUTY_W{1'b0}}, duty} * {{CFG_DUTY_W{1'b0}}, ramp};
      prod = prod >> pwm_bits;
      case (mode)
         MODE_OFF:    eff_duty = '0;
         MODE_STEADY: eff_duty = duty;
         MODE_BLINK:  eff_duty = blink_on ? duty : '0;
         default:     eff_duty = prod[CFG_DUTY_W-1:0];
      endcase
   endfunction

endpackage

// File: rtl/rgb_led_pwm_chan.sv
// One RGB LED channel: pending/active configuration and three registered
// PWM pin drivers. Shared counters (pwm, blink, ramp) come from the top.
module rgb_led_pwm_chan
   import rgb_led_pkg::*;
#(
   parameter int PWM_BITS   = 8,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_we,
   input  logic [MODE_W-1:0]   i_mode,
   input  logic [PWM_BITS-1:0] i_r,
   input  logic [PWM_BITS-1:0] i_g,
   input  logic [PWM_BITS-1:0] i_b,
   input  logic [PWM_BITS-1:0] i_pwm_cnt,
   input  logic                i_frame_end,
   input  logic                i_blink_on,
   input  logic [PWM_BITS-1:0] i_ramp,
   output logic [2:0]          o_pins
);

   led_cfg_t              w_wr_cfg;
   led_cfg_t              r_pend;
   led_cfg_t              r_act;
   logic [CFG_DUTY_W-1:0] w_pwm;
   logic [CFG_DUTY_W-1:0] w_ramp;
   logic [CFG_DUTY_W-1:0] w_eff_r;
   logic [CFG_DUTY_W-1:0] w_eff_g;
   logic [CFG_DUTY_W-1:0] w_eff_b;
   logic [2:0]            w_lit;

   assign w_wr_cfg = '{mode: led_mode_e'(i_mode),
                       r:    CFG_DUTY_W'(i_r),
                       g:    CFG_DUTY_W'(i_g),
                       b:    CFG_DUTY_W'(i_b)};

   assign w_pwm  = CFG_DUTY_W'(i_pwm_cnt);
   assign w_ramp = CFG_DUTY_W'(i_ramp);

   // Duty is taken from the active copy only, so it never changes mid-frame.
   assign w_eff_r = eff_duty(r_act.mode, r_act.r, i_blink_on, w_ramp, PWM_BITS);
   assign w_eff_g = eff_duty(r_act.mode, r_act.g, i_blink_on, w_ramp, PWM_BITS);
   assign w_eff_b = eff_duty(r_act.mode, r_act.b, i_blink_on, w_ramp, PWM_BITS);

   assign w_lit = {(w_pwm < w_eff_r), (w_pwm < w_eff_g), (w_pwm < w_eff_b)};

   // Pending slot takes every write; active copies pending at the frame end,
   // and a write landing on the frame-end cycle goes straight to active too.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pend <= CFG_RESET;
         r_act  <= CFG_RESET;
      end else begin
         if (i_frame_end) begin
            r_act <= r_pend;
         end
         if (i_we) begin
            r_pend <= w_wr_cfg;
            if (i_frame_end) begin
               r_act <= w_wr_cfg;
            end
         end
      end
   end

   // Registered pin drive; reset parks the pins at the inactive level.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_pins <= {3{ACTIVE_LOW}};
      end else begin
         o_pins <= w_lit ^ {3{ACTIVE_LOW}};
      end
   end

endmodule

// File: rtl/rgb_led_pwm_ctrl.sv
// Multi-LED RGB PWM controller with off/steady/blink/breathe modes.
// Owns the shared pwm, blink and breathe-ramp counters and fans a one-cycle
// configuration write out to N_LEDS channel instances.
//
// Config port: cfg_we is a single-cycle write strobe with no ready signal;
// every write is accepted in the cycle it is presented. Writes whose cfg_idx
// is not below N_LEDS are dropped. rst is asserted asynchronously and is
// expected to be released synchronously to clk_100mhz.
module rgb_led_pwm_ctrl
   import rgb_led_pkg::*;
#(
   parameter int N_LEDS        = 4,
   parameter int PWM_BITS      = 8,
   parameter int BLINK_BITS    = 27,
   parameter int RAMP_DIV_BITS = 16,
   parameter bit ACTIVE_LOW    = 1'b1,
   parameter int IDXW          = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
   input  logic                clk_100mhz,
   input  logic                rst,
   input  logic                cfg_we,
   input  logic [IDXW-1:0]     cfg_idx,
   input  logic [MODE_W-1:0]   cfg_mode,
   input  logic [PWM_BITS-1:0] cfg_r,
   input  logic [PWM_BITS-1:0] cfg_g,
   input  logic [PWM_BITS-1:0] cfg_b,
   output logic                frame_start,
   output logic [N_LEDS-1:0]   ledR,
   output logic [N_LEDS-1:0]   ledG,
   output logic [N_LEDS-1:0]   ledB
);

   localparam logic [PWM_BITS-1:0]      PWM_MAX = '1;
   localparam logic [RAMP_DIV_BITS-1:0] DIV_MAX = '1;

   logic [PWM_BITS-1:0]      r_pwm_cnt;
   logic                     r_frame_start;
   logic [BLINK_BITS-1:0]    r_blink_cnt;
   logic [RAMP_DIV_BITS-1:0] r_ramp_div;
   logic [PWM_BITS-1:0]      r_ramp;
   ramp_dir_e                r_ramp_dir;

   logic [PWM_BITS-1:0]      w_ramp_nxt;
   ramp_dir_e                w_ramp_dir_nxt;
   logic                     w_frame_end;
   logic                     w_blink_on;
   logic                     w_ramp_step;

   assign w_frame_end = (r_pwm_cnt == PWM_MAX);
   assign w_blink_on  = r_blink_cnt[BLINK_BITS-1];
   assign w_ramp_step = (r_ramp_div == DIV_MAX);
   assign frame_start = r_frame_start;

   // Free-running PWM frame counter and the frame-start pulse that follows
   // the last count of each frame.
   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         r_pwm_cnt     <= '0;
         r_frame_start <= 1'b0;
      end else begin
         r_pwm_cnt     <= r_pwm_cnt + 1'b1;
         r_frame_start <= w_frame_end;
      end
   end

   // Blink phase counter and breathe prescaler, both free-running.
   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         r_blink_cnt <= '0;
         r_ramp_div  <= '0;
      end else begin
         r_blink_cnt <= r_blink_cnt + 1'b1;
         r_ramp_div  <= r_ramp_div + 1'b1;
      end
   end

   // Breathe ramp state register.
   always_ff @(posedge clk_100mhz or posedge rst) begin
      if (rst) begin
         r_ramp     <= '0;
         r_ramp_dir <= RAMP_UP;
      end else begin
         r_ramp     <= w_ramp_nxt;
         r_ramp_dir <= w_ramp_dir_nxt;
      end
   end

   // Breathe ramp next state: on an end value the step only flips the
   // direction, which holds that end value for one extra step.
   always_comb begin
      w_ramp_nxt     = r_ramp;
      w_ramp_dir_nxt = r_ramp_dir;
      if (w_ramp_step) begin
         case (r_ramp_dir)
            RAMP_UP: begin
               if (r_ramp == PWM_MAX) begin
                  w_ramp_dir_nxt = RAMP_DOWN;
               end else begin
                  w_ramp_nxt = r_ramp + 1'b1;
               end
            end
            default: begin
               if (r_ramp == '0) begin
                  w_ramp_dir_nxt = RAMP_UP;
               end else begin
                  w_ramp_nxt = r_ramp - 1'b1;
               end
            end
         endcase
      end
   end

   for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_led
      logic       w_we;
      logic [2:0] w_pins;

      assign w_we = cfg_we && (cfg_idx == IDXW'(gi));

      rgb_led_pwm_chan #(
         .PWM_BITS   (PWM_BITS),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_chan (
         .i_clk       (clk_100mhz),
         .i_rst       (rst),
         .i_we        (w_we),
         .i_mode      (cfg_mode),
         .i_r         (cfg_r),
         .i_g         (cfg_g),
         .i_b         (cfg_b),
         .i_pwm_cnt   (r_pwm_cnt),
         .i_frame_end (w_frame_end),
         .i_blink_on  (w_blink_on),
         .i_ramp      (r_ramp),
         .o_pins      (w_pins)
      );

      assign ledR[gi] = w_pins[2];
      assign ledG[gi] = w_pins[1];
      assign ledB[gi] = w_pins[0];
   end

endmodule

// File: tb/tb_rgb_led_pwm_ctrl.sv
// Bench for rgb_led_pwm_ctrl: directed steps plus random writes, every cycle
// compared against a frame/blink/ramp model derived from plain arithmetic.
module tb_rgb_led_pwm_ctrl;

   localparam int N       = 4;
   localparam int PW      = 4;
   localparam int BB      = 6;
   localparam int RD      = 2;
   localparam int IW      = 3;
   localparam int FRAME   = 1 << PW;
   localparam int BLINK_P = 1 << BB;
   localparam int STEP    = 1 << RD;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_we;
   logic [IW-1:0] cfg_idx;
   logic [1:0]    cfg_mode;
   logic [PW-1:0] cfg_r;
   logic [PW-1:0] cfg_g;
   logic [PW-1:0] cfg_b;
   logic          frame_start;
   logic [N-1:0]  ledR;
   logic [N-1:0]  ledG;
   logic [N-1:0]  ledB;

   always #5 clk = ~clk;

   rgb_led_pwm_ctrl #(
      .N_LEDS        (N),
      .PWM_BITS      (PW),
      .BLINK_BITS    (BB),
      .RAMP_DIV_BITS (RD),
      .ACTIVE_LOW    (1'b1),
      .IDXW          (IW)
   ) dut (
      .clk_100mhz  (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_idx     (cfg_idx),
      .cfg_mode    (cfg_mode),
      .cfg_r       (cfg_r),
      .cfg_g       (cfg_g),
      .cfg_b       (cfg_b),
      .frame_start (frame_start),
      .ledR        (ledR),
      .ledG        (ledG),
      .ledB        (ledB)
   );

   // ---------------- reference model ----------------
   typedef struct {
      int mode;
      int r;
      int g;
      int b;
   } mcfg_t;

   mcfg_t pend[N];
   mcfg_t act[N];
   int    n;          // clock edges since reset release
   int    first_fs;
   int    total = 0;
   int    bad   = 0;
   logic [12:0] exp_q[$];

   // Triangle with one repeat at each end: 0..MAX, MAX..0, period 2*FRAME steps.
   function automatic int ramp_at(int nn);
      int p;
      p = (nn / STEP) % (2 * FRAME);
      return (p < FRAME) ? p : (2 * FRAME - 1 - p);
   endfunction

   function automatic int model_eff(int mode, int d, int nn);
      case (mode)
         0:       return 0;
         1:       return d;
         2:       return ((nn % BLINK_P) >= BLINK_P / 2) ? d : 0;
         default: return (d * ramp_at(nn)) / FRAME;
      endcase
   endfunction

   // Expected {frame_start, ledR, ledG, ledB} after the edge leaving state nn.
   function automatic logic [12:0] model_pins(int nn);
      logic [12:0] v;
      int          pwm;
      pwm   = nn % FRAME;
      v[12] = (pwm == FRAME - 1);
      for (int i = 0; i < N; i++) begin
         v[8+i] = !(pwm < model_eff(act[i].mode, act[i].r, nn));
         v[4+i] = !(pwm < model_eff(act[i].mode, act[i].g, nn));
         v[i]   = !(pwm < model_eff(act[i].mode, act[i].b, nn));
      end
      return v;
   endfunction

   task automatic model_reset();
      n = 0;
      for (int i = 0; i < N; i++) begin
         pend[i] = '{0, 0, 0, 0};
         act[i]  = '{0, 0, 0, 0};
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // ---------------- driver tasks ----------------
   // One clock cycle with an optional write; called at posedge+1.
   task automatic cycle(input logic we, input int idx, input int mode,
                        input int r, input int g, input int b);
      logic [12:0] obs;
      logic        boundary;
      exp_q.push_back(model_pins(n));
      cfg_we   = we;
      cfg_idx  = IW'(idx);
      cfg_mode = 2'(mode);
      cfg_r    = PW'(r);
      cfg_g    = PW'(g);
      cfg_b    = PW'(b);
      boundary = ((n % FRAME) == FRAME - 1);
      if (boundary) begin
         for (int i = 0; i < N; i++) act[i] = pend[i];
      end
      if (we && idx < N) begin
         pend[idx] = '{mode, r, g, b};
         if (boundary) act[idx] = pend[idx];
      end
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      n++;
      obs = {frame_start, ledR, ledG, ledB};
      check($sformatf("pins@n=%0d", n), 32'(obs), 32'(exp_q.pop_front()));
      if (frame_start && first_fs < 0) first_fs = n;
   endtask

   task automatic idle(input int k);
      repeat (k) cycle(1'b0, 0, 0, 0, 0, 0);
   endtask

   // Runs until the model's pwm count equals k (at most one frame).
   task automatic align(input int k);
      for (int i = 0; i < FRAME && (n % FRAME) != k; i++) idle(1);
   endtask

   task automatic count_low(input int k, input int led,
                            output int cr, output int cg, output int cb);
      cr = 0;
      cg = 0;
      cb = 0;
      repeat (k) begin
         idle(1);
         cr += int'(!ledR[led]);
         cg += int'(!ledG[led]);
         cb += int'(!ledB[led]);
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      int cr;
      int cg;
      int cb;
      int sum;
      rst      = 1'b1;
      cfg_we   = 1'b0;
      cfg_idx  = '0;
      cfg_mode = '0;
      cfg_r    = '0;
      cfg_g    = '0;
      cfg_b    = '0;
      first_fs = -1;
      model_reset();

      // Reset held 5 cycles: pins inactive, no frame_start.
      repeat (5) begin
         @(posedge clk);
         #1;
         check("reset_pins", 32'({frame_start, ledR, ledG, ledB}), 32'h0FFF);
      end
      rst = 1'b0;
      model_reset();

      // First frame_start in cycle 17 counting the release cycle as cycle 1.
      idle(20);
      check("first_frame_start_cycle", 32'(first_fs + 1), 32'd17);

      // STEADY write mid-frame on LED 1: nothing moves before the boundary.
      cycle(1'b1, 1, 1, 4, 0, 15);
      sum = 0;
      for (int i = 0; i < FRAME && (n % FRAME) != 0; i++) begin
         idle(1);
         sum += int'(!ledR[1]) + int'(!ledG[1]) + int'(!ledB[1]);
      end
      check("steady_pre_boundary_low", 32'(sum), 32'd0);
      idle(2);
      count_low(FRAME, 1, cr, cg, cb);
      check("steady_r4_low", 32'(cr), 32'd4);
      check("steady_g0_low", 32'(cg), 32'd0);
      check("steady_b15_low", 32'(cb), 32'd15);

      // Two writes in one frame on LED 2: last one wins.
      align(2);
      cycle(1'b1, 2, 1, 3, 0, 0);
      idle(3);
      cycle(1'b1, 2, 1, 9, 0, 0);
      idle(FRAME + 1);
      count_low(FRAME, 2, cr, cg, cb);
      check("last_write_r9_low", 32'(cr), 32'd9);

      // Write exactly on pwm==max: visible in the very next frame.
      align(FRAME - 1);
      cycle(1'b1, 2, 1, 5, 0, 0);
      count_low(FRAME, 2, cr, cg, cb);
      check("boundary_write_r5_low", 32'(cr), 32'd5);

      // BLINK r=15 on LED 0: 2 lit frames of 15 per 64-cycle blink period.
      cycle(1'b1, 0, 2, 15, 0, 0);
      idle(40);
      count_low(BLINK_P, 0, cr, cg, cb);
      check("blink_r15_low_per_period", 32'(cr), 32'd30);
      check("blink_g0_low", 32'(cg), 32'd0);

      // BREATHE g=15 on LED 3: full ramp cycle checked cycle by cycle.
      cycle(1'b1, 3, 3, 0, 15, 0);
      idle(2 * FRAME * STEP + 40);

      // Out-of-range index is ignored.
      cycle(1'b1, 5, 1, 15, 15, 15);
      idle(2 * FRAME);
      count_low(FRAME, 1, cr, cg, cb);
      check("idx5_ignored_led1_r", 32'(cr), 32'd4);

      // Random writes, including out-of-range indices.
      repeat (400) begin
         cycle(($urandom_range(0, 3) == 0), $urandom_range(0, 7),
               $urandom_range(0, 3), $urandom_range(0, FRAME - 1),
               $urandom_range(0, FRAME - 1), $urandom_range(0, FRAME - 1));
      end

      // Make sure something is lit, then reset mid-frame asynchronously.
      cycle(1'b1, 1, 1, 15, 15, 15);
      idle(FRAME + 2);
      align(7);
      #1;
      rst = 1'b1;
      #1;
      check("async_reset_pins", 32'({frame_start, ledR, ledG, ledB}), 32'h0FFF);
      repeat (3) begin
         @(posedge clk);
         #1;
         check("held_reset_pins", 32'({frame_start, ledR, ledG, ledB}), 32'h0FFF);
      end
      rst = 1'b0;
      model_reset();
      idle(FRAME + 4);
      sum = 0;
      for (int i = 0; i < N; i++) begin
         count_low(FRAME, i, cr, cg, cb);
         sum += cr + cg + cb;
      end
      check("post_reset_all_off", 32'(sum), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
